half_adder: RTL and testbench

Registered single-bit-slice half adder: for each bit lane it forms sum = a XOR b and carry = a AND b. Lanes are independent; there is no carry propagation between them. It is the primitive arithmetic cell used by wider adder and counter logic. One clock, valid-qualified input, optional output register stage.

---
 rtl/half_adder.sv | 59 +++++
 tb/tb_half_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Registered per-lane half adder: sum = a ^ b, carry = a & b, no carry between lanes.
// PIPE selects a one-cycle registered output stage or a purely combinational path.
module half_adder #(
  parameter int WIDTH = 1,
  parameter bit PIPE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum,
  output logic             carry_any,
  output logic             out_valid
);

  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] sum_c;

  assign carry_c = a & b;
  assign sum_c   = a ^ b;

  generate
    if (PIPE) begin : g_pipe
      logic [WIDTH-1:0] carry_r;
      logic [WIDTH-1:0] sum_r;
      logic             valid_r;

      // Data registers load only on in_valid, so X on a/b while idle never reaches them.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          carry_r <= '0;
          sum_r   <= '0;
          valid_r <= 1'b0;
        end else begin
          valid_r <= in_valid;
          if (in_valid) begin
            carry_r <= carry_c;
            sum_r   <= sum_c;
          end
        end
      end

      assign carry     = carry_r;
      assign sum       = sum_r;
      assign out_valid = valid_r;
    end else begin : g_comb
      // Reset gates the combinational outputs so they read zero while rst_n is low.
      assign carry     = rst_n ? carry_c : '0;
      assign sum       = rst_n ? sum_c   : '0;
      assign out_valid = rst_n & in_valid;
    end
  endgenerate

  // Taken from the output side so it always agrees with carry in the same cycle.
  assign carry_any = |carry;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: registered 1-lane and 4-lane instances plus a
// combinational 1-lane instance, checked against an arithmetic reference model.
module tb_half_adder;

  logic clk;
  logic rst_n;

  logic       a1, b1, v1;
  logic       c1, s1, any1, ov1;
  logic [3:0] a4, b4;
  logic       v4;
  logic [3:0] c4, s4;
  logic       any4, ov4;
  logic       a0, b0, v0;
  logic       c0, s0, any0, ov0;

  int total = 0;
  int bad   = 0;

  half_adder #(.WIDTH(1), .PIPE(1'b1)) u_p1w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .carry(c1), .sum(s1), .carry_any(any1), .out_valid(ov1)
  );

  half_adder #(.WIDTH(4), .PIPE(1'b1)) u_p1w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4),
    .carry(c4), .sum(s4), .carry_any(any4), .out_valid(ov4)
  );

  half_adder #(.WIDTH(1), .PIPE(1'b0)) u_p0w1 (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .in_valid(v0),
    .carry(c0), .sum(s0), .carry_any(any0), .out_valid(ov0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each lane adds two one-bit integers; the two-bit result splits into carry/sum.
  function automatic void ref_add(input logic [3:0] x, input logic [3:0] y, input int w,
                                  output logic [3:0] c, output logic [3:0] s,
                                  output logic any);
    int t;
    c = '0;
    s = '0;
    for (int i = 0; i < w; i++) begin
      t = (x[i] ? 1 : 0) + (y[i] ? 1 : 0);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
    any = (c != 4'd0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    a4 = 4'hf; b4 = 4'hf; v4 = 1'b1;
    a0 = 1'b1; b0 = 1'b1; v0 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({c1, s1, any1, ov1} !== 4'b0000) begin
      bad++; $display("FAIL reset_p1w1 got=%b exp=0000", {c1, s1, any1, ov1});
    end
    total++;
    if ({c4, s4, any4, ov4} !== 10'b0) begin
      bad++; $display("FAIL reset_p1w4 got=%b exp=0", {c4, s4, any4, ov4});
    end
    total++;
    if ({c0, s0, any0, ov0} !== 4'b0000) begin
      bad++; $display("FAIL reset_p0w1 got=%b exp=0000", {c0, s0, any0, ov0});
    end
    v1 = 1'b0; v4 = 1'b0; v0 = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [3:0] ec, es;
    logic       eany;
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      a1 = (v / 2) == 1; b1 = (v % 2) == 1; v1 = 1'b1;
      ref_add({3'b0, a1}, {3'b0, b1}, 1, ec, es, eany);
      @(posedge clk); #1;
      total++;
      if ({c1, s1, any1, ov1} !== {ec[0], es[0], eany, 1'b1}) begin
        bad++;
        $display("FAIL truth_table v=%0d got=%b exp=%b", v, {c1, s1, any1, ov1},
                 {ec[0], es[0], eany, 1'b1});
      end
      v1 = 1'b0;
    end
  endtask

  task automatic test_hold();
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin a1 = 1'bx; b1 = 1'bx; end
      @(posedge clk); #1;
      total++;
      if ({c1, s1, any1, ov1} !== 4'b1010) begin
        bad++; $display("FAIL hold k=%0d got=%b exp=1010", k, {c1, s1, any1, ov1});
      end
    end
    a1 = 1'b0; b1 = 1'b0;
  endtask

  task automatic test_async_reset();
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({c1, s1, ov1} !== 3'b101) begin
      bad++; $display("FAIL areset_capture got=%b exp=101", {c1, s1, ov1});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({c1, s1, any1, ov1} !== 4'b0000) begin
      bad++; $display("FAIL areset_immediate got=%b exp=0000", {c1, s1, any1, ov1});
    end
    @(posedge clk); #1;
    total++;
    if ({c1, s1, any1, ov1} !== 4'b0000) begin
      bad++; $display("FAIL areset_no_capture got=%b exp=0000", {c1, s1, any1, ov1});
    end
    #3 rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({c1, s1, any1, ov1} !== 4'b0101) begin
      bad++; $display("FAIL areset_release got=%b exp=0101", {c1, s1, any1, ov1});
    end
    v1 = 1'b0;
  endtask

  task automatic test_lanes();
    a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({s4, c4, any4, ov4} !== {4'b0110, 4'b1000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL lanes got s=%b c=%b any=%b ov=%b exp s=0110 c=1000 any=1 ov=1",
                      s4, c4, any4, ov4);
    end
    v4 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ov4 !== 1'b0 || s4 !== 4'b0110) begin
      bad++; $display("FAIL lanes_idle got ov=%b s=%b exp ov=0 s=0110", ov4, s4);
    end
  endtask

  task automatic test_comb();
    logic [3:0] ec, es;
    logic       eany;
    for (int v = 0; v < 8; v++) begin
      if (v < 4) begin
        a0 = (v / 2) == 1; b0 = (v % 2) == 1; v0 = (v % 2) == 0;
      end else begin
        a0 = $urandom_range(1, 0) == 1; b0 = $urandom_range(1, 0) == 1;
        v0 = $urandom_range(1, 0) == 1;
      end
      ref_add({3'b0, a0}, {3'b0, b0}, 1, ec, es, eany);
      #1;
      total++;
      if ({c0, s0, any0, ov0} !== {ec[0], es[0], eany, v0}) begin
        bad++;
        $display("FAIL comb v=%0d got=%b exp=%b", v, {c0, s0, any0, ov0},
                 {ec[0], es[0], eany, v0});
      end
      #9;
    end
    v0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] ea, eb, ec, es;
    logic       eany;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        a4 = 4'($urandom); b4 = 4'($urandom); v4 = 1'b1;
        qa.push_back(a4); qb.push_back(b4);
      end else begin
        v4 = 1'b0;
      end
      @(posedge clk); #1;
      if (i < 8) begin
        ea = qa.pop_front(); eb = qb.pop_front();
        ref_add(ea, eb, 4, ec, es, eany);
        total++;
        if ({c4, s4, any4, ov4} !== {ec, es, eany, 1'b1}) begin
          bad++;
          $display("FAIL b2b i=%0d a=%h b=%h got c=%h s=%h any=%b ov=%b exp c=%h s=%h any=%b ov=1",
                   i, ea, eb, c4, s4, any4, ov4, ec, es, eany);
        end
      end else begin
        total++;
        if (ov4 !== 1'b0) begin
          bad++; $display("FAIL b2b_end got ov=%b exp=0", ov4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_async_reset();
    test_lanes();
    test_comb();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
